// File: rtl/arrow_memory_game.sv
// rtl/arrow_memory_game.sv - arrow sequence memory room game: LFSR-seeded show/repeat rounds, OLED arrows, 7-seg round/idx.
// Optional ARROW_GAME_TIMEOUT_EN adds a per-press INPUT timeout that forces LOSE.
module arrow_memory_game #(
  parameter int SHOW_CYCLES    = 3125000,
  parameter int GAP_CYCLES     = 625000,
  parameter int ROUNDS         = 8,
  parameter int TIMEOUT_CYCLES = 31250000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_game,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnC,
  input  logic [6:0]  X,
  input  logic [6:0]  Y,
  output logic [15:0] pixel_data,
  output logic        end_game,
  output logic        lose,
  output logic [7:0]  seg_an3,
  output logic [7:0]  seg_an2,
  output logic [7:0]  seg_an1,
  output logic [7:0]  seg_an0
);

  typedef enum logic [2:0] {
    S_IDLE, S_SHOW_ON, S_SHOW_GAP, S_INPUT, S_ROUND_OK, S_WIN, S_LOSE
  } state_t;

  localparam logic [24:0] SHOW_LAST = 25'(SHOW_CYCLES - 1);
  localparam logic [24:0] GAP_LAST  = 25'(GAP_CYCLES - 1);
  localparam logic [3:0]  ROUND_MAX = 4'(ROUNDS);
  localparam logic [6:0]  BOX_X [4] = '{7'd40, 7'd40, 7'd8,  7'd72};
  localparam logic [6:0]  BOX_Y [4] = '{7'd4,  7'd44, 7'd24, 7'd24};

  state_t      r_state, w_next;
  logic [15:0] r_lfsr, r_seq, w_seq_n;
  logic [3:0]  r_round, w_round_n;
  logic [2:0]  r_idx, w_idx_n;
  logic [24:0] r_timer, w_timer_n;
  logic [3:0]  w_dirs, w_hit, w_edge;
  logic [1:0]  w_cur;
  logic        w_last;
  logic [15:0] w_pix;
  logic        w_unused;

`ifdef ARROW_GAME_TIMEOUT_EN
  localparam logic [24:0] TIMEOUT_LAST = 25'(TIMEOUT_CYCLES - 1);
  assign w_unused = btnC;
`else
  assign w_unused = btnC | (TIMEOUT_CYCLES == 0);
`endif

  // Direction code is also the bit position: 0=U 1=D 2=L 3=R.
  assign w_dirs = {btnR, btnL, btnD, btnU};
  assign w_cur  = r_seq[{r_idx, 1'b0} +: 2];
  assign w_last = (({1'b0, r_idx} + 4'd1) == r_round);

  function automatic logic in_box(input logic [6:0] x, y, x0, y0);
    return (x >= x0) && (x <= x0 + 7'd15) && (y >= y0) && (y <= y0 + 7'd15);
  endfunction

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      default: return 8'hFF;
    endcase
  endfunction

  always_comb begin
    w_next    = r_state;
    w_seq_n   = r_seq;
    w_round_n = r_round;
    w_idx_n   = r_idx;
    w_timer_n = r_timer;
    if (r_state != S_IDLE && !start_game) begin
      w_next    = S_IDLE;
      w_round_n = 4'd0;
      w_idx_n   = 3'd0;
      w_timer_n = 25'd0;
    end else begin
      case (r_state)
        S_IDLE: if (start_game && !end_game && !lose) begin
          w_next    = S_SHOW_ON;
          w_seq_n   = r_lfsr;
          w_round_n = 4'd1;
          w_idx_n   = 3'd0;
          w_timer_n = 25'd0;
        end
        S_SHOW_ON: if (r_timer == SHOW_LAST) begin
          w_next    = S_SHOW_GAP;
          w_timer_n = 25'd0;
        end else w_timer_n = r_timer + 25'd1;
        S_SHOW_GAP: if (r_timer == GAP_LAST) begin
          w_timer_n = 25'd0;
          if (w_last) begin
            w_next  = S_INPUT;
            w_idx_n = 3'd0;
          end else begin
            w_next  = S_SHOW_ON;
            w_idx_n = r_idx + 3'd1;
          end
        end else w_timer_n = r_timer + 25'd1;
        S_INPUT: if (|w_dirs) begin
          // Exactly one direction must be high and it must match seq[idx].
          if (w_dirs != (4'b0001 << w_cur)) w_next = S_LOSE;
          else begin
            w_timer_n = 25'd0;
            w_idx_n   = r_idx + 3'd1;
            if (w_last) w_next = (r_round == ROUND_MAX) ? S_WIN : S_ROUND_OK;
          end
        end
`ifdef ARROW_GAME_TIMEOUT_EN
        else if (r_timer == TIMEOUT_LAST) w_next = S_LOSE;
        else w_timer_n = r_timer + 25'd1;
`endif
        S_ROUND_OK: if (r_timer == GAP_LAST) begin
          w_next    = S_SHOW_ON;
          w_timer_n = 25'd0;
          w_round_n = r_round + 4'd1;
          w_idx_n   = 3'd0;
        end else w_timer_n = r_timer + 25'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_hit  = '0;
    w_edge = '0;
    for (int k = 0; k < 4; k++) begin
      w_hit[k]  = in_box(X, Y, BOX_X[k], BOX_Y[k]);
      w_edge[k] = w_hit[k] && (X == BOX_X[k] || X == BOX_X[k] + 7'd15 ||
                               Y == BOX_Y[k] || Y == BOX_Y[k] + 7'd15);
    end
    w_pix = 16'h0000;
    case (r_state)
      S_SHOW_ON: if (w_hit[w_cur]) w_pix = 16'hFFE0;
      S_INPUT:   if (|w_edge) w_pix = 16'h001F;
      S_WIN:     w_pix = 16'h07E0;
      S_LOSE:    w_pix = 16'hF800;
      default:   ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_lfsr     <= 16'hACE1;
      r_seq      <= 16'h0000;
      r_round    <= 4'd0;
      r_idx      <= 3'd0;
      r_timer    <= 25'd0;
      pixel_data <= 16'h0000;
      end_game   <= 1'b0;
      lose       <= 1'b0;
      seg_an1    <= 8'hFF;
      seg_an0    <= 8'hFF;
    end else begin
      r_lfsr     <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_state    <= w_next;
      r_seq      <= w_seq_n;
      r_round    <= w_round_n;
      r_idx      <= w_idx_n;
      r_timer    <= w_timer_n;
      pixel_data <= w_pix;
      end_game   <= (w_next == S_WIN);
      lose       <= (w_next == S_LOSE);
      seg_an0    <= (r_state == S_IDLE) ? 8'hFF : seg_digit(r_round);
      seg_an1    <= (r_state == S_INPUT) ? seg_digit({1'b0, r_idx}) : 8'hFF;
    end
  end

  assign seg_an3 = 8'hFF;
  assign seg_an2 = 8'hFF;

endmodule

// File: tb/tb_arrow_memory_game.sv
// tb/tb_arrow_memory_game.sv - directed bench for arrow_memory_game with short phase parameters.
module tb_arrow_memory_game;
  logic        clock = 1'b0;
  logic        reset, start_game, btnU, btnD, btnL, btnR, btnC;
  logic [6:0]  X, Y;
  logic [15:0] pixel_data;
  logic        end_game, lose;
  logic [7:0]  seg_an3, seg_an2, seg_an1, seg_an0;
  logic [15:0] m_lfsr, seq;
  int          checks = 0;
  int          errors = 0;

  arrow_memory_game #(.SHOW_CYCLES(4), .GAP_CYCLES(2), .ROUNDS(2), .TIMEOUT_CYCLES(20)) dut (
    .clock(clock), .reset(reset), .start_game(start_game),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .btnC(btnC),
    .X(X), .Y(Y), .pixel_data(pixel_data), .end_game(end_game), .lose(lose),
    .seg_an3(seg_an3), .seg_an2(seg_an2), .seg_an1(seg_an1), .seg_an0(seg_an0)
  );

  always #5 clock = ~clock;

  // Reference LFSR x^16+x^14+x^13+x^11 seeded 16'hACE1, stepping every cycle.
  always @(posedge clock or posedge reset)
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic press(input logic [1:0] d);
    btnU = (d == 2'd0); btnD = (d == 2'd1); btnL = (d == 2'd2); btnR = (d == 2'd3);
    btnC = 1'b1;
    tick();
    {btnU, btnD, btnL, btnR, btnC} = '0;
  endtask

  task automatic wait_input(input string tag);
    int n;
    tick(); tick();
    n = 0;
    while (seg_an1 == 8'hFF && n < 60) begin tick(); n++; end
    chk(tag, (seg_an1 != 8'hFF), 1);
  endtask

  task automatic center(input logic [1:0] d);
    case (d)
      2'd0: begin X = 7'd47; Y = 7'd10; end
      2'd1: begin X = 7'd47; Y = 7'd50; end
      2'd2: begin X = 7'd15; Y = 7'd30; end
      default: begin X = 7'd79; Y = 7'd30; end
    endcase
  endtask

  initial begin
    int cnt;
    reset = 1'b1; start_game = 1'b0;
    {btnU, btnD, btnL, btnR, btnC} = '0;
    X = 7'd0; Y = 7'd0;
    repeat (3) tick();
    chk("rst_pixel", pixel_data, 16'h0000);
    chk("rst_seg0", seg_an0, 8'hFF);
    reset = 1'b0;
    repeat (50) tick();
    chk("idle_end", end_game, 0);
    chk("idle_lose", lose, 0);
    chk("idle_pixel", pixel_data, 16'h0000);
    chk("idle_seg0", seg_an0, 8'hFF);
    chk("idle_seg3", seg_an3, 8'hFF);

    // Game 1: win both rounds.
    seq = m_lfsr;
    start_game = 1'b1;
    center(seq[1:0]);
    cnt = 0;
    repeat (10) begin tick(); if (pixel_data == 16'hFFE0) cnt++; end
    chk("yellow_cycles", cnt, 4);
    chk("r1_seg0", seg_an0, 8'hF9);
    wait_input("r1_input");
    X = 7'd40; Y = 7'd4; tick();
    chk("outline_corner", pixel_data, 16'h001F);
    X = 7'd47; Y = 7'd10; tick();
    chk("outline_inner", pixel_data, 16'h0000);
    press(seq[1:0]);
    chk("r1_no_win", end_game, 0);
    wait_input("r2_input");
    chk("r2_seg0", seg_an0, 8'hA4);
    press(seq[1:0]);
    tick();
    chk("r2_seg1_idx1", seg_an1, 8'hF9);
    press(seq[3:2]);
    chk("win_end", end_game, 1);
    chk("win_lose", lose, 0);
    tick();
    chk("win_pixel", pixel_data, 16'h07E0);
    start_game = 1'b0;
    tick();
    chk("win_drop", end_game, 0);
    tick();
    chk("idle2_seg0", seg_an0, 8'hFF);
    chk("idle2_pixel", pixel_data, 16'h0000);

    // Game 2: wrong direction in round 1.
    repeat (3) tick();
    seq = m_lfsr;
    start_game = 1'b1;
    wait_input("g2_input");
    press(seq[1:0] + 2'd1);
    chk("wrong_lose", lose, 1);
    chk("wrong_end", end_game, 0);
    X = 7'd0; Y = 7'd0; tick();
    chk("lose_px_00", pixel_data, 16'hF800);
    X = 7'd95; Y = 7'd63; tick();
    chk("lose_px_max", pixel_data, 16'hF800);
    start_game = 1'b0;
    tick();
    chk("lose_drop", lose, 0);

    // Game 3: two directions on the same cycle.
    repeat (3) tick();
    start_game = 1'b1;
    wait_input("g3_input");
    btnU = 1'b1; btnR = 1'b1;
    tick();
    btnU = 1'b0; btnR = 1'b0;
    chk("multi_lose", lose, 1);
    start_game = 1'b0;
    tick();
    chk("multi_drop", lose, 0);

    // Game 4: no presses in INPUT, then reset mid-game.
    repeat (3) tick();
    start_game = 1'b1;
    wait_input("g4_input");
    X = 7'd40; Y = 7'd4;
    chk("idle_in_input", lose, 0);
`ifdef ARROW_GAME_TIMEOUT_EN
    cnt = 0;
    while (!lose && cnt < 40) begin tick(); cnt++; end
    chk("timeout_lose", lose, 1);
    tick();
    chk("timeout_pixel", pixel_data, 16'hF800);
`else
    repeat (1000) tick();
    chk("no_timeout", lose, 0);
    chk("no_timeout_pixel", pixel_data, 16'h001F);
`endif
    reset = 1'b1;
    #1;
    chk("midrst_pixel", pixel_data, 16'h0000);
    chk("midrst_lose", lose, 0);
    chk("midrst_end", end_game, 0);
    chk("midrst_seg0", seg_an0, 8'hFF);
    chk("midrst_seg1", seg_an1, 8'hFF);
    tick();
    reset = 1'b0;
    start_game = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
